alu_controller: RTL and testbench
=================================

ALU_CONTROLLER -- requirements
Module: alu_controller

Interface
REQ-001 The module SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter: DATA_W, default 8, ALU operand and accumulator width.
REQ-003 Parameter: CNT_W, default 4, repeat-count width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 instr_valid  input  1  instruction offered.
REQ-007 instr_ready  output  1  controller can accept an instruction.
REQ-008 instr_load  input  1  1 = load operand into the accumulator; 0 = ALU operation.
REQ-009 instr_op  input  2  ALU opcode: 0 pass, 1 add, 2 subtract, 3 pass.
REQ-010 instr_operand  input  DATA_W  immediate operand.
REQ-011 instr_count  input  CNT_W  number of ALU iterations.
REQ-012 alu_op  output  2  opcode driven to the ALU.
REQ-013 alu_in1  output  DATA_W  accumulator value driven to ALU operand 1.
REQ-014 alu_in2  output  DATA_W  subtrahend driven to ALU operand 2.
REQ-015 alu_in3  output  DATA_W  addend driven to ALU operand 3.
REQ-016 alu_result  input  DATA_W  combinational ALU result.
REQ-017 acc  output  DATA_W  accumulator.
REQ-018 zero  output  1  acc == 0.
REQ-019 busy  output  1  instruction in progress.
REQ-020 done  output  1  one-cycle pulse at instruction completion.

Function
REQ-021 FSM states SHALL be IDLE, EXEC and DONE.
REQ-022 instr_ready SHALL be 1 only in IDLE; a transfer SHALL occur on instr_valid&&instr_ready at a rising edge.
REQ-023 instr_valid outside IDLE SHALL be ignored, with no state or register change.
REQ-024 On accept with instr_load=1: acc SHALL get instr_operand at that edge, and the next state SHALL be DONE.
REQ-025 On accept with instr_load=0 and instr_count=0: acc SHALL be unchanged, and the next state SHALL be DONE.
REQ-026 On accept with instr_load=0 and instr_count=N>0: op, operand and N SHALL be latched, and the next state SHALL be EXEC.
REQ-027 alu_in2 and alu_in3 SHALL both present the latched operand, and alu_op SHALL present the latched op.
REQ-028 alu_in1 SHALL always equal acc.
REQ-029 In EXEC, on each edge, acc SHALL get alu_result and the remaining count SHALL decrement.
REQ-030 EXEC SHALL go to DONE on the edge where remaining count = 1; EXEC therefore lasts exactly N cycles.
REQ-031 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-032 busy SHALL be 1 in EXEC and in DONE.
REQ-033 Arithmetic SHALL be performed by the external ALU, modulo 2^DATA_W: no saturation and no carry/borrow output.
REQ-034 zero SHALL be combinational from acc.
REQ-035 While in IDLE, alu_op SHALL be 0 (pass).

Reset
REQ-036 Reset SHALL set state=IDLE, acc=0, the latched op, operand and count=0, and done=0.
REQ-037 In the cycle after reset, outputs SHALL be instr_ready=1, busy=0, zero=1.
REQ-038 Reset SHALL override any accept or EXEC update in the same cycle; an instruction in progress SHALL be abandoned with no done pulse.

Structure
REQ-039 Shared package alu_pkg SHALL hold: OP_PASS=0, OP_ADD=1, OP_SUB=2, the state encoding, and default DATA_W/CNT_W.
REQ-040 The ALU SHALL be instantiated outside this block, at the parent level.
REQ-041 One sub-module, iter_counter, is natural: a loadable CNT_W down-counter with a last-iteration flag.

Verification
REQ-042 Load 5, then add 3 with count 4 -> acc=17 after 4 EXEC cycles; done pulses once; busy for 5 cycles.
REQ-043 acc=2, then sub 5 with count 1 -> acc=253 (0xFD), zero=0.
REQ-044 acc=6, then sub 3 with count 2 -> acc=0, zero=1.
REQ-045 Add with count 0 -> acc unchanged; done on the cycle after accept.
REQ-046 instr_valid held high throughout a count=3 instruction -> second instruction accepted only after DONE, when instr_ready=1.
REQ-047 Reset asserted in the 2nd EXEC cycle -> next cycle acc=0, IDLE, instr_ready=1, no done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU controller: opcodes, FSM state
// encoding and default widths.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_controller_iter_counter.sv
// Loadable down-counter tracking the remaining ALU iterations. o_last flags
// the final iteration so the controller can leave EXEC on that edge.
module iter_counter
  import alu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  // Load takes priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/alu_controller.sv
// Sequencer for an external combinational ALU. Accepts one instruction at a
// time in IDLE, either loading the accumulator directly or iterating the
// latched opcode/operand against it N times, then pulses done for one cycle.
module alu_controller
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_load,
  input  logic [1:0]        instr_op,
  input  logic [DATA_W-1:0] instr_operand,
  input  logic [CNT_W-1:0]  instr_count,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [DATA_W-1:0] alu_in3,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] acc,
  output logic              zero,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_acc;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_operand;
  logic              w_accept;
  logic              w_exec_start;
  logic              w_last;

  // Remaining-iteration counter, loaded only when an ALU loop starts.
  iter_counter #(
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_exec_start),
    .i_load_val (instr_count),
    .i_dec      (r_state == ST_EXEC),
    .o_last     (w_last)
  );

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake/status decode. Instructions are only seen in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    instr_ready  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    alu_op       = r_op;
    w_accept     = 1'b0;
    w_exec_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        alu_op      = OP_PASS;
        if (instr_valid) begin
          w_accept = 1'b1;
          if (!instr_load && (instr_count != '0)) begin
            w_exec_start = 1'b1;
            w_state_nxt  = ST_EXEC;
          end else begin
            w_state_nxt  = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Accumulator: direct load on accept, ALU writeback on every EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_accept && instr_load) begin
      r_acc <= instr_operand;
    end else if (r_state == ST_EXEC) begin
      r_acc <= alu_result;
    end
  end

  // Opcode/operand held stable for the whole iteration loop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= OP_PASS;
      r_operand <= '0;
    end else if (w_exec_start) begin
      r_op      <= instr_op;
      r_operand <= instr_operand;
    end
  end

  assign alu_in1 = r_acc;
  assign alu_in2 = r_operand;
  assign alu_in3 = r_operand;
  assign acc     = r_acc;
  assign zero    = (r_acc == '0);

endmodule

// File: tb/tb_alu_controller.sv
// Scoreboard bench for alu_controller with a behavioural ALU and an
// arithmetic reference model of the accumulator.
module tb_alu_controller;
  import alu_pkg::*;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic          instr_load;
  logic [1:0]    instr_op;
  logic [DW-1:0] instr_operand;
  logic [CW-1:0] instr_count;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_in1, alu_in2, alu_in3, alu_result, acc;
  logic          zero, busy, done;

  alu_controller #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_load(instr_load), .instr_op(instr_op), .instr_operand(instr_operand),
    .instr_count(instr_count), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_in3(alu_in3), .alu_result(alu_result), .acc(acc), .zero(zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External ALU model: add uses operand 3, subtract uses operand 2.
  always_comb begin
    case (alu_op)
      2'd1:    alu_result = alu_in1 + alu_in3;
      2'd2:    alu_result = alu_in1 - alu_in2;
      default: alu_result = alu_in1;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] acc;
    int            done_cyc;
    int            busy_len;
  } exp_t;

  exp_t          sbq[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model_acc = '0;
  bit            mon_en = 1'b0;
  int            busy_run = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: structural invariants every cycle, scoreboard pop on each done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      busy_run = busy ? busy_run + 1 : 0;
      chk("ready_is_not_busy", int'(instr_ready), int'(!busy));
      if (instr_ready) chk("idle_alu_op_pass", int'(alu_op), 0);
      chk("alu_in1_is_acc", int'(alu_in1), int'(acc));
      chk("alu_in2_is_in3", int'(alu_in2), int'(alu_in3));
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("done_acc", int'(acc), int'(e.acc));
          chk("done_zero", int'(zero), int'(e.acc == '0));
          chk("done_cycle", cyc, e.done_cyc);
          chk("busy_length", busy_run, e.busy_len);
        end
      end
    end
  end

  // Offers an instruction (valid held) until accepted; returns at the negedge after accept.
  task automatic issue(input bit ld, input logic [1:0] op, input logic [DW-1:0] opnd,
                       input logic [CW-1:0] cnt);
    int   waited = 0;
    exp_t e;
    bit   loops;
    instr_valid   = 1'b1;
    instr_load    = ld;
    instr_op      = op;
    instr_operand = opnd;
    instr_count   = cnt;
    while (!instr_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    loops = !ld && (cnt != 0);
    if (ld) model_acc = opnd;
    else if (op == OP_ADD) model_acc = model_acc + DW'(int'(cnt) * int'(opnd));
    else if (op == OP_SUB) model_acc = model_acc - DW'(int'(cnt) * int'(opnd));
    e.acc      = model_acc;
    e.done_cyc = cyc + 1 + (loops ? int'(cnt) : 0);
    e.busy_len = loops ? int'(cnt) + 1 : 1;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int waited = 0;
    instr_valid = 1'b0;
    while ((sbq.size() != 0 || !instr_ready) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sbq.size() != 0 || !instr_ready) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0; instr_load = 1'b0; instr_op = '0;
    instr_operand = '0; instr_count = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", int'(instr_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_zero", int'(zero), 1);
    chk("reset_acc", int'(acc), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_alu_op", int'(alu_op), 0);
    mon_en = 1'b1;

    // Load 5, add 3 four times.
    issue(1'b1, OP_PASS, 8'd5, 4'd0);
    issue(1'b0, OP_ADD, 8'd3, 4'd4);
    wait_idle();
    chk("load5_add3x4", int'(acc), 17);

    // 2 - 5 wraps.
    issue(1'b1, OP_PASS, 8'd2, 4'd0);
    issue(1'b0, OP_SUB, 8'd5, 4'd1);
    wait_idle();
    chk("sub_wrap_acc", int'(acc), 253);
    chk("sub_wrap_zero", int'(zero), 0);

    // 6 - 3 - 3 reaches zero.
    issue(1'b1, OP_PASS, 8'd6, 4'd0);
    issue(1'b0, OP_SUB, 8'd3, 4'd2);
    wait_idle();
    chk("sub_to_zero_acc", int'(acc), 0);
    chk("sub_to_zero_flag", int'(zero), 1);

    // Count 0 leaves acc alone.
    issue(1'b1, OP_PASS, 8'd42, 4'd0);
    issue(1'b0, OP_ADD, 8'd9, 4'd0);
    wait_idle();
    chk("count0_acc", int'(acc), 42);

    // Back-to-back with valid never dropping.
    issue(1'b1, OP_PASS, 8'd10, 4'd0);
    issue(1'b0, OP_ADD, 8'd1, 4'd3);
    issue(1'b0, OP_SUB, 8'd4, 4'd1);
    wait_idle();
    chk("held_valid_acc", int'(acc), 9);

    // Random instruction stream.
    for (int i = 0; i < 40; i++) begin
      int gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
      issue(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
            8'($urandom), 4'($urandom_range(0, 5)));
    end
    wait_idle();

    // Reset during the second EXEC cycle abandons the instruction.
    issue(1'b1, OP_PASS, 8'd7, 4'd0);
    wait_idle();
    issue(1'b0, OP_ADD, 8'd1, 4'd3);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("exec_progress", int'(acc), 8);
    reset = 1'b1;
    sbq.delete();
    model_acc = '0;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_acc", int'(acc), 0);
    chk("midreset_ready", int'(instr_ready), 1);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_zero", int'(zero), 1);
    chk("midreset_done", int'(done), 0);
    idle(4);

    // Controller still works after the abandoned instruction.
    issue(1'b1, OP_PASS, 8'h55, 4'd0);
    issue(1'b0, OP_ADD, 8'd1, 4'd2);
    wait_idle();
    chk("post_reset_acc", int'(acc), 8'h57);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
